// File: rtl/seg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_pkg
// Shared definitions for the 7-segment scan controller.
//   SEG_OFF        : all segments dark (active-low encoding {g,f,e,d,c,b,a})
//   scan_state_t   : per-slot phase, BLANK (anti-ghosting gap) or SHOW
//   HEX_SEG_TABLE  : nibble -> active-low segment pattern, index 0 first
// -----------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // With a [0:15] range the leftmost concatenation element lands at index 0.
  localparam logic [0:15][6:0] HEX_SEG_TABLE = {
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg_hex_decoder
// Combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   nibble : in  4  hex digit value
//   seg    : out 7  segments {g,f,e,d,c,b,a}, active low
// -----------------------------------------------------------------------------
module seg_hex_decoder
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup; every nibble value has an entry.
  always_comb begin
    seg = HEX_SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode 7-segment bank. One digit
// is driven per slot; each slot opens with a dark gap to avoid ghosting. Display
// data is snapshotted once per frame so mid-frame input changes never tear.
// Ports:
//   clk         : in  1             system clock, rising edge
//   reset       : in  1             asynchronous, active-high reset
//   value_in    : in  4*NUM_DIGITS  nibble k -> digit k (digit 0 rightmost)
//   digit_en    : in  NUM_DIGITS    1 = digit k may light
//   dp_in       : in  NUM_DIGITS    1 = decimal point of digit k lit
//   lz_suppress : in  1             1 = blank leading-zero digits
//   an_out      : out NUM_DIGITS    anode selects, active low, at most one low
//   seg_out     : out 7             segments {g,f,e,d,c,b,a}, active low
//   dp_out      : out 1             decimal point, active low
//   frame_start : out 1             pulse on first cycle of the digit 0 slot
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int CNT_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // run_r stays low for the first clock after reset release so that the cycle
  // following that edge is the frame start with cnt=0.
  logic                    run_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  scan_state_t             state_r;

  logic [4*NUM_DIGITS-1:0] sh_val_r;
  logic [NUM_DIGITS-1:0]   sh_en_r;
  logic [NUM_DIGITS-1:0]   sh_dp_r;
  logic                    sh_lz_r;

  logic [NUM_DIGITS-1:0]   an_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic                    frame_start_r;

  logic [CNT_W-1:0]        cnt_nxt_s;
  logic [IDX_W-1:0]        idx_nxt_s;
  scan_state_t             state_nxt_s;

  logic [4*NUM_DIGITS-1:0] sh_val_nxt_s;
  logic [NUM_DIGITS-1:0]   sh_en_nxt_s;
  logic [NUM_DIGITS-1:0]   sh_dp_nxt_s;
  logic                    sh_lz_nxt_s;

  logic [NUM_DIGITS-1:0]   supp_s;
  logic                    zero_run_s;
  logic [3:0]              nibble_s;
  logic [6:0]              dec_seg_s;
  logic                    lit_s;

  logic [NUM_DIGITS-1:0]   an_nxt_s;
  logic [6:0]              seg_nxt_s;
  logic                    dp_nxt_s;
  logic                    frame_start_nxt_s;

  // Slot counter and digit index advance.
  always_comb begin
    cnt_nxt_s = cnt_r;
    idx_nxt_s = idx_r;
    if (!run_r) begin
      cnt_nxt_s = '0;
      idx_nxt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s = '0;
      if (idx_r == IDX_LAST) begin
        idx_nxt_s = '0;
      end else begin
        idx_nxt_s = idx_r + IDX_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Slot phase transitions: BLANK ends after BLANK_TICKS, SHOW ends with the slot.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BLANK: begin
        if (run_r && (cnt_r == BLANK_LAST)) begin
          state_nxt_s = ST_SHOW;
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_BLANK;
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      default: state_nxt_s = ST_BLANK;
    endcase
  end

  // Snapshot is taken on the edge closing the frame_start cycle.
  always_comb begin
    if (frame_start_r) begin
      sh_val_nxt_s = value_in;
      sh_en_nxt_s  = digit_en;
      sh_dp_nxt_s  = dp_in;
      sh_lz_nxt_s  = lz_suppress;
    end else begin
      sh_val_nxt_s = sh_val_r;
      sh_en_nxt_s  = sh_en_r;
      sh_dp_nxt_s  = sh_dp_r;
      sh_lz_nxt_s  = sh_lz_r;
    end
  end

  // Leading-zero mask: walk from the top digit while every nibble seen is zero.
  // Digit enables are deliberately ignored here.
  always_comb begin
    zero_run_s = 1'b1;
    supp_s     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run_s = zero_run_s & (sh_val_nxt_s[4*k +: 4] == 4'h0);
      if (k >= 1) begin
        supp_s[k] = sh_lz_nxt_s & zero_run_s;
      end else begin
        supp_s[k] = 1'b0;
      end
    end
  end

  assign nibble_s = sh_val_nxt_s[{idx_nxt_s, 2'b00} +: 4];

  seg_hex_decoder u_dec (
    .nibble (nibble_s),
    .seg    (dec_seg_s)
  );

  // Output values for the cycle the next state describes.
  always_comb begin
    lit_s = (state_nxt_s == ST_SHOW) && sh_en_nxt_s[idx_nxt_s] && !supp_s[idx_nxt_s];
    if (lit_s) begin
      an_nxt_s  = ~(NUM_DIGITS'(1) << idx_nxt_s);
      seg_nxt_s = dec_seg_s;
      dp_nxt_s  = ~sh_dp_nxt_s[idx_nxt_s];
    end else begin
      an_nxt_s  = '1;
      seg_nxt_s = SEG_OFF;
      dp_nxt_s  = 1'b1;
    end
    frame_start_nxt_s = (idx_nxt_s == '0) && (cnt_nxt_s == '0);
  end

  // Scan state, snapshot and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_r         <= 1'b0;
      cnt_r         <= '0;
      idx_r         <= '0;
      state_r       <= ST_BLANK;
      sh_val_r      <= '0;
      sh_en_r       <= '0;
      sh_dp_r       <= '0;
      sh_lz_r       <= 1'b0;
      an_r          <= '1;
      seg_r         <= SEG_OFF;
      dp_r          <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      run_r         <= 1'b1;
      cnt_r         <= cnt_nxt_s;
      idx_r         <= idx_nxt_s;
      state_r       <= state_nxt_s;
      sh_val_r      <= sh_val_nxt_s;
      sh_en_r       <= sh_en_nxt_s;
      sh_dp_r       <= sh_dp_nxt_s;
      sh_lz_r       <= sh_lz_nxt_s;
      an_r          <= an_nxt_s;
      seg_r         <= seg_nxt_s;
      dp_r          <= dp_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  assign an_out      = an_r;
  assign seg_out     = seg_r;
  assign dp_out      = dp_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with 4 digits, 10 ticks/slot, 2 blank
// ticks. A frame-level model predicts every output each cycle; directed points
// carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int ND  = 4;
  localparam int TPD = 10;
  localparam int BT  = 2;
  localparam int FRM = ND * TPD;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   value_in;
  logic [3:0]    digit_en;
  logic [3:0]    dp_in;
  logic          lz_suppress;
  logic [3:0]    an_out;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic          frame_start;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Cycle number since reset release; -1 while in reset or before first edge.
  int cyc = -1;

  logic [15:0] s_val;
  logic [3:0]  s_en;
  logic [3:0]  s_dp;
  logic        s_lz;

  seg_scan_ctrl #(
    .NUM_DIGITS      (ND),
    .TICKS_PER_DIGIT (TPD),
    .BLANK_TICKS     (BT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .lz_suppress (lz_suppress),
    .an_out      (an_out),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] tb_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Per-cycle model comparison on the falling edge.
  initial begin : compare_proc
    int          off;
    int          slot;
    logic        lit;
    logic [3:0]  nib;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_an", an_out, 4'hF);
        check("rst_seg", seg_out, 7'h7F);
        check("rst_dp", dp_out, 1'b1);
        check("rst_fs", frame_start, 1'b0);
        cyc   = -1;
        s_val = 16'h0;
        s_en  = 4'h0;
        s_dp  = 4'h0;
        s_lz  = 1'b0;
      end else if (cyc < 0) begin
        check("pre_an", an_out, 4'hF);
        check("pre_fs", frame_start, 1'b0);
        cyc = 0;
      end else begin
        off  = cyc % TPD;
        slot = (cyc / TPD) % ND;
        nib  = s_val[4*slot +: 4];
        lit  = (off >= BT) && s_en[slot] &&
               !((slot >= 1) && s_lz && ((s_val >> (4*slot)) == 16'h0));
        e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
        e_seg = lit ? tb_seg(nib) : 7'h7F;
        e_dp  = lit ? ~s_dp[slot] : 1'b1;
        check("model_an", an_out, e_an);
        check("model_seg", seg_out, e_seg);
        check("model_dp", dp_out, e_dp);
        check("model_fs", frame_start, (cyc % FRM) == 0);
        check("onehot_an", ($countones(~an_out) <= 1), 1'b1);
        if ((cyc % FRM) == 0) begin
          s_val = value_in;
          s_en  = digit_en;
          s_dp  = dp_in;
          s_lz  = lz_suppress;
        end
        cyc++;
      end
    end
  end

  // Advance to just after the rising edge that starts cycle n.
  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      check("wait_timeout", cyc, n);
    end
  endtask

  initial begin
    reset       = 1'b1;
    value_in    = 16'h1234;
    digit_en    = 4'hF;
    dp_in       = 4'h0;
    lz_suppress = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic scan of 1234
    wait_cyc(0);  check("c0_fs", frame_start, 1'b1); check("c0_an", an_out, 4'hF);
                  check("c0_seg", seg_out, 7'h7F);
    wait_cyc(1);  check("c1_fs", frame_start, 1'b0); check("c1_an", an_out, 4'hF);
    wait_cyc(2);  check("c2_an", an_out, 4'b1110); check("c2_seg", seg_out, 7'b0011001);
    wait_cyc(12); check("c12_an", an_out, 4'b1101); check("c12_seg", seg_out, 7'b0110000);
    wait_cyc(15); value_in = 16'hABCD;
    wait_cyc(22); check("c22_an", an_out, 4'b1011); check("c22_seg", seg_out, 7'b0100100);
    wait_cyc(32); check("c32_an", an_out, 4'b0111); check("c32_seg", seg_out, 7'b1111001);
    wait_cyc(40); check("c40_fs", frame_start, 1'b1);
    wait_cyc(42); check("c42_an", an_out, 4'b1110); check("c42_seg", seg_out, 7'b0100001);

    // Leading-zero suppression
    wait_cyc(45); lz_suppress = 1'b1; value_in = 16'h0050;
    wait_cyc(82);  check("lz_d0_an", an_out, 4'b1110); check("lz_d0_seg", seg_out, 7'b1000000);
    wait_cyc(92);  check("lz_d1_an", an_out, 4'b1101); check("lz_d1_seg", seg_out, 7'b0010010);
    wait_cyc(100); value_in = 16'h0000;
    wait_cyc(102); check("lz_d2_an", an_out, 4'hF);
    wait_cyc(112); check("lz_d3_an", an_out, 4'hF);
    wait_cyc(122); check("z_d0_an", an_out, 4'b1110); check("z_d0_seg", seg_out, 7'b1000000);
    wait_cyc(132); check("z_d1_an", an_out, 4'hF);
    wait_cyc(142); check("z_d2_an", an_out, 4'hF);

    // Digit enables and decimal points
    wait_cyc(150); lz_suppress = 1'b0; value_in = 16'h1234; digit_en = 4'b1010; dp_in = 4'b0010;
    wait_cyc(152); check("z_d3_an", an_out, 4'hF);
    wait_cyc(162); check("en_d0_an", an_out, 4'hF); check("en_d0_dp", dp_out, 1'b1);
    wait_cyc(172); check("en_d1_an", an_out, 4'b1101); check("en_d1_seg", seg_out, 7'b0110000);
                   check("en_d1_dp", dp_out, 1'b0);
    wait_cyc(175); digit_en = 4'hF; dp_in = 4'h0;
    wait_cyc(182); check("en_d2_an", an_out, 4'hF);
    wait_cyc(192); check("en_d3_an", an_out, 4'b0111); check("en_d3_dp", dp_out, 1'b1);

    // Reset in the middle of digit 2 SHOW
    wait_cyc(225); check("pre_rst_an", an_out, 4'b1011); check("pre_rst_seg", seg_out, 7'b0100100);
    #1 reset = 1'b1;
    #1 check("mid_rst_an", an_out, 4'hF); check("mid_rst_seg", seg_out, 7'h7F);
       check("mid_rst_dp", dp_out, 1'b1); check("mid_rst_fs", frame_start, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_cyc(0); check("rr_c0_fs", frame_start, 1'b1);
    wait_cyc(1); check("rr_c1_an", an_out, 4'hF);
    wait_cyc(2); check("rr_c2_an", an_out, 4'b1110); check("rr_c2_seg", seg_out, 7'b0011001);

    // Nibble sweep on digit 0, one value per frame
    for (int n = 0; n < 16; n++) begin
      wait_cyc(FRM*n + 20);
      value_in = 16'(n);
      wait_cyc(FRM*(n+1) + 5);
      check("sweep_an", an_out, 4'b1110);
      check("sweep_seg", seg_out, tb_seg(4'(n)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
